fir_stream_host: RTL

Host-side controller that drives the FIR top level through its native handshake. It converts an upstream valid/ready sample stream into FIR `data_in` beats under `start_coe`/`hold` control, and captures FIR `data_out` whenever `start_toread` fires. Captured results are buffered in an output FIFO and presented as a valid/ready stream. It sits between the sample source/sink fabric and the FIR, as the opposite end of the FIR's start/hold protocol.

---
 rtl/fir_stream_host_if.sv | 11 +
 rtl/fir_stream_host.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_host_if.sv
// Valid/ready stream bundle carrying samples into and results out of fir_stream_host.
interface fir_stream_host_if #(
  parameter int unsigned DataW = 32
);
  logic             valid;
  logic             ready;
  logic [DataW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fir_stream_host.sv
// Host side of the FIR start/hold protocol: feeds samples, captures results into an output FIFO.
// Optional COEFF watchdog and err_timeout enabled by defining FIR_HOST_TIMEOUT_EN.
module fir_stream_host #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned DRAIN_CYCLES = 7,
  parameter int unsigned COEFF_WAIT   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_go,
  input  logic               cfg_stop,
  fir_stream_host_if.slave   in_if,
  output logic [31:0]        fir_data_in,
  output logic               fir_start_coe,
  output logic               fir_hold,
  input  logic               fir_start_togivedata,
  input  logic               fir_start_toread,
  input  logic [31:0]        fir_data_out,
  fir_stream_host_if.master  out_if,
  output logic               busy,
  output logic               err_timeout,
  output logic               err_overflow
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned DrnW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StCoeff, StStream, StDrain} state_e;

  state_e          state_q, state_d;
  logic            coe_q, coe_d;
  logic [31:0]     data_in_q, data_in_d;
  logic [DrnW-1:0] drain_cnt_q, drain_cnt_d;
  logic            err_ovf_q, err_ovf_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     mem_q [DEPTH];
  logic            empty, full, almost_full, push, pop, hold, in_ready, accept;

`ifdef FIR_HOST_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(COEFF_WAIT + 1);
  logic [WdW-1:0] wd_q, wd_d;
  logic           err_to_q, err_to_d;
`else
  logic unused_coeff_wait;
  assign unused_coeff_wait = ^COEFF_WAIT;
`endif

  assign empty       = (count_q == '0);
  assign full        = (count_q == CntW'(DEPTH));
  assign almost_full = (count_q >= CntW'(DEPTH - 2));
  assign pop         = !empty && out_if.ready;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign push        = fir_start_toread && (!full || pop);

  always_comb begin
    hold     = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      StStream: begin
        hold     = !in_if.valid || almost_full;
        in_ready = fir_start_togivedata && !hold;
      end
      StDrain: hold = almost_full;
      default: ;
    endcase
  end

  assign accept = in_if.valid && in_ready;

  always_comb begin
    state_d     = state_q;
    coe_d       = coe_q;
    data_in_d   = data_in_q;
    drain_cnt_d = drain_cnt_q;
    err_ovf_d   = err_ovf_q;
    wr_ptr_d    = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d     = count_q + CntW'(push) - CntW'(pop);
`ifdef FIR_HOST_TIMEOUT_EN
    wd_d        = wd_q;
    err_to_d    = err_to_q;
`endif
    case (state_q)
      StIdle: begin
        if (cfg_go) begin
          state_d   = StCoeff;
          coe_d     = 1'b1;
          err_ovf_d = 1'b0;
`ifdef FIR_HOST_TIMEOUT_EN
          err_to_d  = 1'b0;
          wd_d      = '0;
`endif
        end
      end
      StCoeff: begin
        if (fir_start_togivedata) begin
          state_d = StStream;
`ifdef FIR_HOST_TIMEOUT_EN
        end else if (wd_q == WdW'(COEFF_WAIT - 1)) begin
          state_d  = StIdle;
          coe_d    = 1'b0;
          err_to_d = 1'b1;
        end else begin
          wd_d = wd_q + WdW'(1);
`endif
        end
      end
      StStream: begin
        if (accept) data_in_d = in_if.data;
        if (cfg_stop) begin
          state_d     = StDrain;
          drain_cnt_d = '0;
        end
      end
      StDrain: begin
        data_in_d = '0;
        if (fir_start_toread) begin
          if (drain_cnt_q == DrnW'(DRAIN_CYCLES - 1)) begin
            state_d = StIdle;
            coe_d   = 1'b0;
          end else begin
            drain_cnt_d = drain_cnt_q + DrnW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (fir_start_toread && full && !pop) err_ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      coe_q       <= 1'b0;
      data_in_q   <= '0;
      drain_cnt_q <= '0;
      err_ovf_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
`ifdef FIR_HOST_TIMEOUT_EN
      wd_q        <= '0;
      err_to_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      coe_q       <= coe_d;
      data_in_q   <= data_in_d;
      drain_cnt_q <= drain_cnt_d;
      err_ovf_q   <= err_ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
`ifdef FIR_HOST_TIMEOUT_EN
      wd_q        <= wd_d;
      err_to_q    <= err_to_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= fir_data_out;
  end

  assign in_if.ready   = in_ready;
  assign out_if.valid  = !empty;
  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign out_if.data   = empty ? '0 : mem_q[rd_ptr_q];
  assign fir_data_in   = data_in_q;
  assign fir_start_coe = coe_q;
  assign fir_hold      = hold;
  assign busy          = (state_q != StIdle);
  assign err_overflow  = err_ovf_q;
`ifdef FIR_HOST_TIMEOUT_EN
  assign err_timeout   = err_to_q;
`else
  assign err_timeout   = 1'b0;
`endif

endmodule
